// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic tile feeder.
// Holds the default element width and tile size, the feeder FSM encoding and
// helpers that size the beat, step and flush counters.
package systolic_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int N_DEF          = 4;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FLUSH  = 2'd2
   } feed_state_e;

   // Width of a counter that must hold 0..n-1 (at least one bit).
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of the streaming step counter: steps run 0..2n-2.
   function automatic int step_w(input int n);
      return $clog2(2 * n);
   endfunction

endpackage

// File: rtl/skew_mux.sv
// One output lane of the tile feeder.
// Picks element LANE of column (t - LANE) at step t, or zero when that column
// lies outside the tile; this produces the diagonal skew across lanes.
//   row_i  : element LANE of every tile column, indexed by column
//   t_i    : streaming step being issued
//   lane_o : data for this lane at step t_i
module skew_mux
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int N          = N_DEF,
   parameter int LANE       = 0,
   parameter int STEP_W     = step_w(N)
) (
   input  logic [N-1:0][DATA_WIDTH-1:0] row_i,
   input  logic [STEP_W-1:0]            t_i,
   output logic [DATA_WIDTH-1:0]        lane_o
);

   // Compare against every legal (LANE + column) value instead of subtracting,
   // so no out-of-range column index is ever formed.
   always_comb begin
      lane_o = '0;
      for (int c = 0; c < N; c++) begin
         if (t_i == STEP_W'(LANE + c)) lane_o = row_i[c];
      end
   end

endmodule

// File: rtl/tile_feeder.sv
// Tile feeder for an N-lane systolic array.
// Loads an NxN tile one column per beat, then streams it diagonally skewed
// over 2N-1 steps followed by FLUSH zero cycles. All outputs are registered.
//   clk, rst           : clock, asynchronous active-high reset
//   s_valid/s_ready    : column beat handshake (ready only while loading)
//   s_data             : one tile column, element i in slice i
//   stall              : downstream hold, takes effect on the next cycle
//   out_valid/out_data : shared lane shift-enable and per-lane data
//   tile_done          : pulse on the last issued flush cycle
module tile_feeder
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int N          = N_DEF,
   parameter int FLUSH      = N + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [N*DATA_WIDTH-1:0] s_data,
   input  logic                    stall,
   output logic                    out_valid,
   output logic [N*DATA_WIDTH-1:0] out_data,
   output logic                    tile_done
);

   localparam int STEP_W = step_w(N);
   localparam int BEAT_W = cnt_w(N);
   localparam int FL_W   = cnt_w(FLUSH);

   feed_state_e                              state_q, state_d;
   logic [BEAT_W-1:0]                        beat_q, beat_d;
   logic [STEP_W-1:0]                        t_q, t_d;
   logic [FL_W-1:0]                          fl_q, fl_d;
   logic [N-1:0][N-1:0][DATA_WIDTH-1:0]      mem_q, mem_d;   // [column][element]
   logic                                     ov_q, ov_d;
   logic                                     done_q, done_d;
   logic [N-1:0][DATA_WIDTH-1:0]             out_data_q, out_data_d;
   logic [N-1:0][DATA_WIDTH-1:0]             lane_data;
   logic                                     ld_data, zero_data;

   // t_q / fl_q name the step most recently issued; an issue edge computes
   // the following step and registers its data so outputs never see stall
   // or s_valid combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_LOAD;
         beat_q     <= '0;
         t_q        <= '0;
         fl_q       <= '0;
         mem_q      <= '0;
         ov_q       <= 1'b0;
         done_q     <= 1'b0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         t_q        <= t_d;
         fl_q       <= fl_d;
         mem_q      <= mem_d;
         ov_q       <= ov_d;
         done_q     <= done_d;
         out_data_q <= out_data_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      t_d       = t_q;
      fl_d      = fl_q;
      mem_d     = mem_q;
      ov_d      = 1'b0;
      done_d    = 1'b0;
      ld_data   = 1'b0;
      zero_data = 1'b0;
      unique case (state_q)
         ST_LOAD: begin
            if (s_valid) begin
               for (int c = 0; c < N; c++) begin
                  if (beat_q == BEAT_W'(c)) mem_d[c] = s_data;
               end
               if (beat_q == BEAT_W'(N - 1)) begin
                  // Step 0 issues right after the last beat lands; it reads
                  // mem_d so the just-written column is visible.
                  state_d = ST_STREAM;
                  beat_d  = '0;
                  t_d     = '0;
                  ov_d    = 1'b1;
                  ld_data = 1'b1;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         ST_STREAM: begin
            if (!stall) begin
               ov_d    = 1'b1;
               ld_data = 1'b1;
               if (t_q == STEP_W'(2 * N - 2)) begin
                  state_d   = ST_FLUSH;
                  fl_d      = '0;
                  zero_data = 1'b1;
                  done_d    = (FLUSH == 1);
               end else begin
                  t_d = t_q + STEP_W'(1);
               end
            end
         end
         ST_FLUSH: begin
            if (fl_q == FL_W'(FLUSH - 1)) begin
               // Last flush cycle already issued: leave regardless of stall.
               state_d   = ST_LOAD;
               t_d       = '0;
               fl_d      = '0;
               ld_data   = 1'b1;
               zero_data = 1'b1;
            end else if (!stall) begin
               ov_d      = 1'b1;
               ld_data   = 1'b1;
               zero_data = 1'b1;
               fl_d      = fl_q + FL_W'(1);
               done_d    = (fl_d == FL_W'(FLUSH - 1));
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // Lane muxes look at the next step and the tile as it will be after
   // this edge.
   for (genvar g = 0; g < N; g++) begin : g_lane
      logic [N-1:0][DATA_WIDTH-1:0] row;
      always_comb begin
         for (int c = 0; c < N; c++) row[c] = mem_d[c][g];
      end
      skew_mux #(
         .DATA_WIDTH (DATA_WIDTH),
         .N          (N),
         .LANE       (g),
         .STEP_W     (STEP_W)
      ) u_mux (
         .row_i  (row),
         .t_i    (t_d),
         .lane_o (lane_data[g])
      );
   end

   // Data is held whenever nothing is issued (stall or load).
   always_comb begin
      out_data_d = out_data_q;
      if (ld_data) out_data_d = zero_data ? '0 : lane_data;
   end

   assign s_ready   = (state_q == ST_LOAD);
   assign out_valid = ov_q;
   assign out_data  = out_data_q;
   assign tile_done = done_q;

endmodule

// File: tb/tb_tile_feeder.sv
module tb_tile_feeder;
   localparam int DW = 8;
   localparam int N  = 4;
   localparam int FL = N + 1;
   localparam int NI = 2 * N - 1 + FL;

   logic          clk = 1'b0;
   logic          rst, s_valid, s_ready, stall, out_valid, tile_done;
   logic [N*DW-1:0] s_data, out_data;

   int n_chk = 0;
   int n_pass = 0;

   logic [31:0] colA[N];
   logic [31:0] expA[NI];
   logic [31:0] col7[N];
   logic [31:0] exp7[NI];

   always #5 clk = ~clk;

   tile_feeder #(.DATA_WIDTH(DW), .N(N), .FLUSH(FL)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .stall     (stall),
      .out_valid (out_valid),
      .out_data  (out_data),
      .tile_done (tile_done)
   );

   // lane0 in the low byte
   function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
      return {d[7:0], c[7:0], b[7:0], a[7:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Feed the N columns; gap idle cycles between beats.
   task automatic load(input bit use7, input int gap);
      for (int b = 0; b < N; b++) begin
         int w;
         w = 0;
         s_valid = 1'b1;
         s_data  = use7 ? col7[b] : colA[b];
         while (!s_ready && w < 40) begin
            step();
            w++;
         end
         chk($sformatf("ready_beat%0d", b), 32'(s_ready), 32'd1);
         step();
         if (b < N - 1) begin
            for (int g = 0; g < gap; g++) begin
               s_valid = 1'b0;
               s_data  = '1;
               chk("ready_gap", 32'(s_ready), 32'd1);
               step();
            end
         end
      end
      s_valid = 1'b0;
      s_data  = '0;
   endtask

   // Collect issued cycles until stop_at of them are seen; stalls stall_len
   // cycles once stall_at steps have been issued.
   task automatic run(input bit use7, input int stall_at, input int stall_len, input int stop_at);
      int k, low, left, cyc;
      logic [31:0] e, last;
      k = 0; low = 0; left = stall_len; cyc = 0; last = '0;
      while (k < stop_at && cyc < 60) begin
         if (out_valid) begin
            e = use7 ? exp7[k] : expA[k];
            chk($sformatf("data_c%0d", k), out_data, e);
            chk($sformatf("done_c%0d", k), 32'(tile_done), 32'(k == NI - 1));
            chk("ready_busy", 32'(s_ready), 32'd0);
            last = e;
            k++;
         end else begin
            low++;
            chk("hold_data", out_data, last);
            chk("done_low", 32'(tile_done), 32'd0);
         end
         stall = (k == stall_at && left > 0);
         if (stall) left--;
         cyc++;
         if (k < stop_at) step();
      end
      stall = 1'b0;
      chk("issued", 32'(k), 32'(stop_at));
      chk("low_cycles", 32'(low), 32'(stall_len));
   endtask

   initial begin
      colA[0] = pk(1, 2, 3, 4);
      colA[1] = pk(5, 6, 7, 8);
      colA[2] = pk(9, 10, 11, 12);
      colA[3] = pk(13, 14, 15, 16);
      expA[0] = pk(1, 0, 0, 0);
      expA[1] = pk(5, 2, 0, 0);
      expA[2] = pk(9, 6, 3, 0);
      expA[3] = pk(13, 10, 7, 4);
      expA[4] = pk(0, 14, 11, 8);
      expA[5] = pk(0, 0, 15, 12);
      expA[6] = pk(0, 0, 0, 16);
      for (int i = 0; i < N; i++) col7[i] = pk(7, 7, 7, 7);
      exp7[0] = pk(7, 0, 0, 0);
      exp7[1] = pk(7, 7, 0, 0);
      exp7[2] = pk(7, 7, 7, 0);
      exp7[3] = pk(7, 7, 7, 7);
      exp7[4] = pk(0, 7, 7, 7);
      exp7[5] = pk(0, 0, 7, 7);
      exp7[6] = pk(0, 0, 0, 7);
      for (int i = 2 * N - 1; i < NI; i++) begin
         expA[i] = '0;
         exp7[i] = '0;
      end

      rst = 1'b1; s_valid = 1'b0; s_data = '0; stall = 1'b0;
      #1;
      chk("rst_ready", 32'(s_ready), 32'd1);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_done", 32'(tile_done), 32'd0);
      step(); step();
      rst = 1'b0;
      step();

      // basic tile
      load(0, 0);
      run(0, -1, 0, NI);
      step();
      chk("ready_after_basic", 32'(s_ready), 32'd1);

      // 3-cycle stall after step 1 is issued
      load(0, 0);
      run(0, 2, 3, NI);
      step();
      chk("ready_after_stall", 32'(s_ready), 32'd1);

      // gapped beats, stall held high during load (ignored there)
      stall = 1'b1;
      load(0, 2);
      run(0, -1, 0, NI);
      step();

      // reset in the middle of streaming, then an all-7 tile
      load(0, 0);
      run(0, -1, 0, 5);
      rst = 1'b1;
      #1;
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_data", out_data, 32'd0);
      chk("midrst_done", 32'(tile_done), 32'd0);
      chk("midrst_ready", 32'(s_ready), 32'd1);
      step();
      rst = 1'b0;
      load(1, 0);
      run(1, -1, 0, NI);
      step();

      // s_valid held high through streaming; next tile follows directly
      load(0, 0);
      s_valid = 1'b1;
      s_data  = colA[0];
      run(0, -1, 0, NI);
      step();
      chk("ready_b2b", 32'(s_ready), 32'd1);
      load(0, 0);
      run(0, -1, 0, NI);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
